// File: rtl/mips32_fetch_unit.sv
// mips32_fetch_unit: instruction-fetch stage of the mips32 core.
// Owns the PC and a synchronous-read instruction memory. Fetched words go
// into a 2-entry {pc, instr} FIFO that feeds decode over valid/ready.
// Execute can redirect the PC; a redirect flushes everything in flight.
// Optional feature macro: MIPS32_FETCH_PERF_EN adds a 32-bit fetch_count
// output that counts completed decode handshakes.
module mips32_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 32,
  parameter int          IMEM_AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef MIPS32_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count
`endif
);

  // Instruction storage; contents are loaded from outside, there is no write port.
  logic [31:0] instructions [0:IMEM_DEPTH-1];

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] rdata_q;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, instr0_q, instr0_d;
  logic [31:0] pc1_q, pc1_d, instr1_q, instr1_d;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic [1:0]  count_after_pop;

  // Handshake and issue decision: only issue when the returning word is sure to fit.
  always_comb begin
    pop       = (count_q != 2'd0) & out_ready;
    push      = inflight_q;
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (occupancy < 3'd2);
  end

  // Next state for the FIFO (pop first, then append) and the fetch pointer.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    inflight_d      = 1'b0;
    inflight_pc_d   = inflight_pc_q;
    pc0_d           = pc0_q;
    instr0_d        = instr0_q;
    pc1_d           = pc1_q;
    instr1_d        = instr1_q;
    count_after_pop = count_q;

    if (pop) begin
      pc0_d           = pc1_q;
      instr0_d        = instr1_q;
      count_after_pop = count_q - 2'd1;
    end

    count_d = count_after_pop;
    if (push) begin
      if (count_after_pop == 2'd0) begin
        pc0_d    = inflight_pc_q;
        instr0_d = rdata_q;
      end else begin
        pc1_d    = inflight_pc_q;
        instr1_d = rdata_q;
      end
      count_d = count_after_pop + 2'd1;
    end

    if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end

    // A redirect drops the FIFO and the pending read; the target issues next cycle.
    if (redirect_valid) begin
      count_d    = 2'd0;
      inflight_d = 1'b0;
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      count_q       <= 2'd0;
      pc0_q         <= 32'd0;
      instr0_q      <= 32'd0;
      pc1_q         <= 32'd0;
      instr1_q      <= 32'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      pc0_q         <= pc0_d;
      instr0_q      <= instr0_d;
      pc1_q         <= pc1_d;
      instr1_q      <= instr1_d;
    end
  end

  // Synchronous memory read of the current fetch address; only used when issued.
  always_ff @(posedge clk) begin
    rdata_q <= instructions[fetch_pc_q[IMEM_AW+1:2]];
  end

  // Outputs come from the FIFO head and are forced to zero when it is empty.
  always_comb begin
    out_valid = (count_q != 2'd0);
    out_pc    = out_valid ? pc0_q : 32'd0;
    out_instr = out_valid ? instr0_q : 32'd0;
  end

`ifdef MIPS32_FETCH_PERF_EN
  logic [31:0] fetch_count_q;

  // Completed-handshake counter; survives redirects, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
    end else if (pop) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Directed testbench for mips32_fetch_unit: reset, streaming, back-pressure,
// redirect with a simultaneous pop, memory aliasing and mid-stream reset.
module tb_mips32_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outPc;
  logic [31:0] outInstr;
`ifdef MIPS32_FETCH_PERF_EN
  logic [31:0] fetchCount;
`endif

  int numChecks = 0;
  int numFails  = 0;

  mips32_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_DEPTH(32),
    .IMEM_AW   (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirectValid),
    .redirect_pc   (redirectPc),
    .out_valid     (outValid),
    .out_ready     (outReady),
    .out_pc        (outPc),
    .out_instr     (outInstr)
`ifdef MIPS32_FETCH_PERF_EN
    ,
    .fetch_count   (fetchCount)
`endif
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge, where outputs are sampled and inputs changed.
  task automatic step();
    @(negedge clk);
  endtask

  // Drive all DUT inputs at once.
  task automatic applyStimulus(input logic rstV, input logic redirV,
                               input logic [31:0] redirPcV, input logic readyV);
    rst           = rstV;
    redirectValid = redirV;
    redirectPc    = redirPcV;
    outReady      = readyV;
  endtask

  // Compare the three output signals against hand-computed values.
  task automatic checkOutput(input string tag, input logic expValid,
                             input logic [31:0] expPc, input logic [31:0] expInstr);
    numChecks++;
    assert (outValid === expValid) else begin
      numFails++;
      $error("[TB] FAIL %s out_valid got %0b expected %0b", tag, outValid, expValid);
    end
    numChecks++;
    assert (outPc === expPc) else begin
      numFails++;
      $error("[TB] FAIL %s out_pc got %08h expected %08h", tag, outPc, expPc);
    end
    numChecks++;
    assert (outInstr === expInstr) else begin
      numFails++;
      $error("[TB] FAIL %s out_instr got %08h expected %08h", tag, outInstr, expInstr);
    end
  endtask

`ifdef MIPS32_FETCH_PERF_EN
  // Compare the performance counter against an expected pop count.
  task automatic checkCount(input string tag, input logic [31:0] expCount);
    numChecks++;
    assert (fetchCount === expCount) else begin
      numFails++;
      $error("[TB] FAIL %s fetch_count got %0d expected %0d", tag, fetchCount, expCount);
    end
  endtask
`endif

  // Directed sequence; every check happens on a falling edge.
  initial begin
    logic [31:0] pcExp;

    for (int k = 0; k < 32; k++) begin
      dut.instructions[k] = 32'h1000_0000 + k;
    end

    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
    repeat (2) step();
    $display("[TB] reset state");
    checkOutput("reset", 1'b0, 32'd0, 32'd0);
`ifdef MIPS32_FETCH_PERF_EN
    checkCount("countReset", 32'd0);
`endif

    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    step();
    checkOutput("latency1", 1'b0, 32'd0, 32'd0);
    step();

    $display("[TB] streaming from reset");
    for (int k = 0; k < 2; k++) begin
      checkOutput("stream", 1'b1, 32'(4 * k), 32'h1000_0000 + 32'(k));
      step();
    end

    $display("[TB] back-pressure at pc 0x8");
    checkOutput("stallStart", 1'b1, 32'h8, 32'h1000_0002);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("stallHold", 1'b1, 32'h8, 32'h1000_0002);
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    step();
    checkOutput("resumeC", 1'b1, 32'hC, 32'h1000_0003);
    step();
    checkOutput("resume10", 1'b1, 32'h10, 32'h1000_0004);

    $display("[TB] misaligned redirect to 0x43 together with pop of 0x10");
    applyStimulus(1'b0, 1'b1, 32'h43, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("redirGap1", 1'b0, 32'd0, 32'd0);
    step();
    checkOutput("redirGap2", 1'b0, 32'd0, 32'd0);
    step();

    $display("[TB] stream from 0x40 through memory wrap");
    for (int j = 0; j <= 16; j++) begin
      pcExp = 32'h40 + 32'(4 * j);
      checkOutput("wrapStream", 1'b1, pcExp, 32'h1000_0000 + {27'd0, pcExp[6:2]});
      if (j < 16) step();
    end

    $display("[TB] fill FIFO then reset mid-stream");
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    step();
    checkOutput("fullHold1", 1'b1, 32'h80, 32'h1000_0000);
    step();
    checkOutput("fullHold2", 1'b1, 32'h80, 32'h1000_0000);
`ifdef MIPS32_FETCH_PERF_EN
    checkCount("countBeforeReset", 32'd21);
`endif
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    checkOutput("midReset", 1'b0, 32'd0, 32'd0);
`ifdef MIPS32_FETCH_PERF_EN
    checkCount("countMidReset", 32'd0);
`endif
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    step();
    checkOutput("restartGap", 1'b0, 32'd0, 32'd0);
    step();

    $display("[TB] restart from RESET_PC, ten pops");
    for (int i = 0; i < 10; i++) begin
      checkOutput("restart", 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i));
      step();
    end
    checkOutput("afterTen", 1'b1, 32'h28, 32'h1000_000A);
`ifdef MIPS32_FETCH_PERF_EN
    checkCount("countTen", 32'd10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
